// File: rtl/col_readout_arbiter.sv
// col_readout_arbiter: round-robin column grant with index-tagged output FIFO
module col_readout_arbiter #(
   parameter int N_COL      = 8,
   parameter int DATA_W     = 26,
   parameter int IDX_W      = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk_40MHz,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [N_COL-1:0]          col_valid,
   input  logic [N_COL*DATA_W-1:0]   col_data_bus,
   output logic [N_COL-1:0]          shake_hands_col,
   output logic [IDX_W+DATA_W-1:0]   out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      fifo_full,
   output logic [15:0]               word_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = IDX_W + DATA_W;
   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
   state_t state;
   logic [IDX_W-1:0] ptr, sel, pick, idx;
   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic wr, rd;
   // highest-to-lowest scan so the column nearest the pointer wins
   always_comb begin
      pick = ptr;
      idx = '0;
      for (int i = N_COL - 1; i >= 0; i--) begin
         idx = ptr + IDX_W'(i);
         if (col_valid[idx]) pick = idx;
      end
   end
   assign wr = state == GRANT;
   assign rd = out_valid & out_ready;
   assign out_valid = count != '0;
   assign fifo_full = count == (AW+1)'(FIFO_DEPTH);
   assign out_data = mem[rd_ptr];
   always_ff @(posedge clk_40MHz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         sel <= '0;
         shake_hands_col <= '0;
      end else begin
         case (state)
            IDLE: if (enable && |col_valid && !fifo_full) begin
               sel <= pick;
               shake_hands_col <= N_COL'(1) << pick;
               state <= GRANT;
            end
            GRANT: begin
               shake_hands_col <= '0;
               ptr <= sel + IDX_W'(1);
               state <= HOLD;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_40MHz or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         word_cnt <= '0;
      end else begin
         if (wr) mem[wr_ptr] <= {sel, col_data_bus[sel*DATA_W +: DATA_W]};
         wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
         word_cnt <= (wr && word_cnt != 16'hFFFF) ? word_cnt + 16'd1 : word_cnt;
      end
   end
endmodule

// File: tb/tb_col_readout_arbiter.sv
// tb_col_readout_arbiter: directed scenarios plus random traffic against a queue-based reference
module tb_col_readout_arbiter;
   localparam int N = 8, DW = 26, IW = 3, D = 8;
   logic clk = 0, rst = 1, enable = 0, out_ready = 0;
   logic [N-1:0] col_valid = '0;
   logic [N*DW-1:0] bus;
   logic [N-1:0] shake;
   logic [IW+DW-1:0] out_data;
   logic out_valid, fifo_full;
   logic [15:0] word_cnt;
   logic [DW-1:0] cd [N];
   int n_vec = 0, n_err = 0, cyc = 0, wcol = -1;
   bit auto_mode = 0;
   int m_ptr, m_gnt, m_hold;
   logic [15:0] m_cnt;
   logic [IW+DW-1:0] m_q [$];
   int g_col [$], g_cyc [$];

   col_readout_arbiter dut (
      .clk_40MHz(clk), .rst(rst), .enable(enable), .col_valid(col_valid),
      .col_data_bus(bus), .shake_hands_col(shake), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_full(fifo_full),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus = '0;
      for (int k = 0; k < N; k++) bus[k*DW +: DW] = cd[k];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_gnt = -1; m_hold = 0; m_cnt = 0;
      m_q.delete();
   endtask

   // one clock edge of the reference: pop, pending write, then a fresh grant decision
   task automatic model_step(output int w);
      bit was_full;
      w = -1;
      if (rst) begin
         model_reset();
         return;
      end
      was_full = m_q.size() == D;
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (m_gnt >= 0) begin
         m_q.push_back({IW'(m_gnt), cd[m_gnt]});
         if (m_cnt != 16'hFFFF) m_cnt++;
         m_ptr = (m_gnt + 1) % N;
         w = m_gnt;
         m_gnt = -1;
         m_hold = 1;
      end else if (m_hold) begin
         m_hold = 0;
      end else if (enable && col_valid != 0 && !was_full) begin
         for (int i = 0; i < N; i++)
            if (m_gnt < 0 && col_valid[(m_ptr + i) % N]) m_gnt = (m_ptr + i) % N;
      end
   endtask

   task automatic check_outputs();
      chk("shake", shake, m_gnt >= 0 ? 64'(1) << m_gnt : 64'(0));
      chk("out_valid", out_valid, m_q.size() != 0);
      chk("fifo_full", fifo_full, m_q.size() == D);
      chk("word_cnt", word_cnt, m_cnt);
      if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
      for (int k = 0; k < N; k++)
         if (shake[k]) begin
            g_col.push_back(k);
            g_cyc.push_back(cyc);
         end
   endtask

   task automatic tick();
      model_step(wcol);
      @(negedge clk);
      cyc++;
      check_outputs();
      if (auto_mode) begin
         for (int k = 0; k < N; k++)
            if (k == wcol) begin
               col_valid[k] = $urandom_range(1, 0) == 1;
               cd[k] = DW'($urandom);
            end else if (!col_valid[k] && $urandom_range(3, 0) == 0) begin
               col_valid[k] = 1;
               cd[k] = DW'($urandom);
            end
         enable = $urandom_range(9, 0) != 0;
         out_ready = $urandom_range(1, 0) == 1;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      chk("rst_data", out_data, 0);
      chk("rst_shake", shake, 0);
      rst = 0;
      g_col.delete();
      g_cyc.delete();
   endtask

   task automatic all_valid();
      col_valid = '1;
      for (int k = 0; k < N; k++) cd[k] = DW'(k);
   endtask

   initial begin
      model_reset();
      for (int k = 0; k < N; k++) cd[k] = '0;
      @(negedge clk);
      do_reset();
      // single hit on column 3
      enable = 1; out_ready = 1;
      col_valid = 8'h08; cd[3] = 26'h155_AAAA;
      tick();
      chk("single_shake", shake, 8'h08);
      col_valid = '0;
      tick();
      chk("single_data", out_data, {3'd3, 26'h155_AAAA});
      chk("single_cnt", word_cnt, 1);
      ticks(4);
      chk("single_pulses", g_col.size(), 1);
      // fairness
      do_reset();
      all_valid();
      ticks(48);
      chk("fair_n", g_col.size(), 16);
      for (int i = 0; i < g_col.size() && i < 16; i++) chk("fair_order", g_col[i], i % N);
      for (int i = 1; i < g_cyc.size() && i < 16; i++) chk("fair_gap", g_cyc[i] - g_cyc[i-1], 3);
      chk("fair_cnt", word_cnt, 16);
      // backpressure
      do_reset();
      out_ready = 0;
      ticks(32);
      chk("bp_full", fifo_full, 1);
      chk("bp_cnt", word_cnt, 8);
      chk("bp_grants", g_col.size(), 8);
      out_ready = 1;
      tick();
      out_ready = 0;
      ticks(3);
      chk("bp_regrant", g_col.size(), 9);
      // enable drop during grant
      do_reset();
      out_ready = 1;
      tick();
      chk("en_shake", shake, 8'h01);
      enable = 0;
      ticks(8);
      chk("en_cnt", word_cnt, 1);
      chk("en_grants", g_col.size(), 1);
      enable = 1;
      ticks(3);
      chk("en_resume_n", g_col.size(), 2);
      if (g_col.size() > 1) chk("en_resume_col", g_col[1], 1);
      // reset during HOLD with 5 words stored
      do_reset();
      out_ready = 0;
      ticks(14);
      chk("mid_cnt", word_cnt, 5);
      rst = 1;
      tick();
      chk("mid_valid", out_valid, 0);
      chk("mid_cnt0", word_cnt, 0);
      chk("mid_data", out_data, 0);
      rst = 0;
      tick();
      chk("mid_ptr", shake, 8'h01);
      // saturation starting just below the limit
      ticks(2);
      out_ready = 1;
      force dut.word_cnt = 16'hFFFC;
      #1 release dut.word_cnt;
      m_cnt = 16'hFFFC;
      ticks(24);
      chk("sat_cnt", word_cnt, 16'hFFFF);
      // random traffic
      do_reset();
      col_valid = '0;
      auto_mode = 1;
      ticks(3000);
      auto_mode = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
